// File: rtl/mips_run_controller_pkg.sv
// Shared types for the MIPS run/step controller and its trace buffer.
// State encoding and trace layout are reused by other MIPS debug blocks.
package mips_run_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RESET_HOLD = 3'd1,
    ST_RUN        = 3'd2,
    ST_STEP       = 3'd3,
    ST_PAUSED     = 3'd4,
    ST_DONE       = 3'd5
  } run_state_e;

  // A trace entry is {pc, alu}
  localparam int TRACE_FIELDS = 2;

  function automatic logic st_cpu_rst(run_state_e s);
    return (s == ST_IDLE) || (s == ST_RESET_HOLD);
  endfunction

  function automatic logic st_en(run_state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

  function automatic logic st_busy(run_state_e s);
    return (s == ST_RESET_HOLD) || (s == ST_RUN) ||
           (s == ST_STEP) || (s == ST_PAUSED);
  endfunction

endpackage

// File: rtl/mips_run_controller_if.sv
// Control, CPU-monitor and trace-readback signals of the run controller.
// slave = controller side, master = host/testbench side.
interface mips_run_controller_if #(
  parameter int DATA_W = 32,
  parameter int STEP_W = 16,
  parameter int ADDR_W = 4
);
  logic                  start;
  logic [STEP_W-1:0]     step_count;
  logic                  halt_req;
  logic                  single_step;
  logic [DATA_W-1:0]     pc_in;
  logic [DATA_W-1:0]     alu_in;
  logic                  cpu_reset;
  logic                  cpu_en;
  logic                  busy;
  logic                  done;
  logic [STEP_W-1:0]     cycles_run;
  logic [ADDR_W-1:0]     trace_rd_addr;
  logic [2*DATA_W-1:0]   trace_rd_data;
  logic [ADDR_W:0]       trace_count;
  logic                  trace_overflow;

  modport slave (
    input  start, step_count, halt_req, single_step,
    input  pc_in, alu_in, trace_rd_addr,
    output cpu_reset, cpu_en, busy, done, cycles_run,
    output trace_rd_data, trace_count, trace_overflow
  );

  modport master (
    output start, step_count, halt_req, single_step,
    output pc_in, alu_in, trace_rd_addr,
    input  cpu_reset, cpu_en, busy, done, cycles_run,
    input  trace_rd_data, trace_count, trace_overflow
  );
endinterface

// File: rtl/mips_run_controller_trace_buf.sv
// Circular {pc,alu} trace RAM with oldest-relative registered read port.
// When full, each write overwrites the oldest entry and sets the sticky overflow.
module mips_run_controller_trace_buf #(
  parameter int DEPTH  = 16,
  parameter int W      = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [W-1:0]      wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [W-1:0]      rd_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o
);

  logic [W-1:0]      mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] oldest_q;
  logic [ADDR_W:0]   count_q;
  logic              ovf_q;
  logic [W-1:0]      rd_q;
  logic              full;
  logic [ADDR_W-1:0] rd_idx;

  assign full   = (count_q == (ADDR_W+1)'(DEPTH));
  assign rd_idx = oldest_q + rd_addr_i;

  always_ff @(posedge clk_i) begin
    if (wr_en_i && rst_ni) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      oldest_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rd_q     <= '0;
    end else begin
      rd_q <= mem_q[rd_idx];
      if (clr_i) begin
        wr_ptr_q <= '0;
        oldest_q <= '0;
        count_q  <= '0;
        ovf_q    <= 1'b0;
      end else if (wr_en_i) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        if (full) begin
          oldest_q <= oldest_q + ADDR_W'(1);
          ovf_q    <= 1'b1;
        end else begin
          count_q  <= count_q + (ADDR_W+1)'(1);
        end
      end
    end
  end

  assign rd_data_o  = rd_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/mips_run_controller.sv
// Run/step controller for the single-cycle MipsCPU: reset hold,
// counted run with halt/single-step, and a circular execution trace.
module mips_run_controller
  import mips_run_controller_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int RESET_CYCLES = 4,
  parameter int STEP_W       = 16,
  parameter int TRACE_DEPTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  mips_run_controller_if.slave   bus
);

  localparam int ADDR_W = $clog2(TRACE_DEPTH);
  localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
  localparam int ENT_W  = TRACE_FIELDS * DATA_W;

  run_state_e        state_q, state_d;
  logic [STEP_W-1:0] target_q, target_d;
  logic [STEP_W-1:0] cycles_q, cycles_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              cpu_reset_q, cpu_en_q, busy_q, done_q;
  logic              trace_clr, trace_wr;
  logic [STEP_W-1:0] cyc_inc;
  logic              launch;

  logic [ENT_W-1:0]  rd_data;
  logic [ADDR_W:0]   t_count;
  logic              t_ovf;

  assign cyc_inc = cycles_q + STEP_W'(1);
  assign launch  = bus.start && (bus.step_count != '0);

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cycles_d  = cycles_q;
    hold_d    = hold_q;
    trace_clr = 1'b0;
    trace_wr  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (launch) begin
          state_d   = ST_RESET_HOLD;
          target_d  = bus.step_count;
          cycles_d  = '0;
          hold_d    = '0;
          trace_clr = 1'b1;
        end
      end
      ST_RESET_HOLD: begin
        if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        trace_wr = 1'b1;
        cycles_d = cyc_inc;
        // Reaching the target beats a same-cycle halt
        if (cyc_inc == target_q) begin
          state_d = ST_DONE;
        end else if (bus.halt_req) begin
          state_d = ST_PAUSED;
        end
      end
      ST_STEP: begin
        trace_wr = 1'b1;
        cycles_d = cyc_inc;
        state_d  = (cyc_inc == target_q) ? ST_DONE : ST_PAUSED;
      end
      ST_PAUSED: begin
        if (bus.start) begin
          state_d = ST_RUN;
        end else if (bus.single_step) begin
          state_d = ST_STEP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      cycles_q    <= '0;
      hold_q      <= '0;
      cpu_reset_q <= 1'b1;
      cpu_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      cycles_q    <= cycles_d;
      hold_q      <= hold_d;
      cpu_reset_q <= st_cpu_rst(state_d);
      cpu_en_q    <= st_en(state_d);
      busy_q      <= st_busy(state_d);
      done_q      <= (state_d == ST_DONE);
    end
  end

  mips_run_controller_trace_buf #(
    .DEPTH  (TRACE_DEPTH),
    .W      (ENT_W),
    .ADDR_W (ADDR_W)
  ) u_trace (
    .clk_i      (clock),
    .rst_ni     (reset),
    .clr_i      (trace_clr),
    .wr_en_i    (trace_wr),
    .wr_data_i  ({bus.pc_in, bus.alu_in}),
    .rd_addr_i  (bus.trace_rd_addr),
    .rd_data_o  (rd_data),
    .count_o    (t_count),
    .overflow_o (t_ovf)
  );

  assign bus.cpu_reset      = cpu_reset_q;
  assign bus.cpu_en         = cpu_en_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.cycles_run     = cycles_q;
  assign bus.trace_rd_data  = rd_data;
  assign bus.trace_count    = t_count;
  assign bus.trace_overflow = t_ovf;

endmodule

// File: tb/tb_mips_run_controller.sv
// Bench for mips_run_controller: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_mips_run_controller;

  localparam int DATA_W = 32;
  localparam int RC     = 4;
  localparam int STEP_W = 16;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  localparam int PH_IDLE  = 0;
  localparam int PH_HOLD  = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_STEP  = 3;
  localparam int PH_PAUSE = 4;
  localparam int PH_DONE  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_run_controller_if #(
    .DATA_W(DATA_W), .STEP_W(STEP_W), .ADDR_W(AW)
  ) bus ();

  mips_run_controller #(
    .DATA_W(DATA_W), .RESET_CYCLES(RC),
    .STEP_W(STEP_W), .TRACE_DEPTH(DEPTH)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase + remaining hold time + executed count + trace queue
  int          ph = PH_IDLE;
  int          hold_left = 0;
  int          target = 0;
  int          exec_n = 0;
  logic [63:0] q[$];
  bit          ovf = 0;
  logic [63:0] rd_exp = '0;
  bit          rd_ok = 0;
  bit          live = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      live = 1; ph = PH_IDLE; exec_n = 0; target = 0;
      q.delete(); ovf = 0; rd_exp = '0; rd_ok = 1;
    end else if (live) begin
      rd_ok = int'(bus.trace_rd_addr) < q.size();
      if (rd_ok) rd_exp = q[bus.trace_rd_addr];
      case (ph)
        PH_IDLE, PH_DONE:
          if (bus.start && bus.step_count != 0) begin
            target = int'(bus.step_count); hold_left = RC;
            exec_n = 0; q.delete(); ovf = 0; ph = PH_HOLD;
          end
        PH_HOLD: begin
          hold_left--;
          if (hold_left == 0) ph = PH_RUN;
        end
        PH_RUN, PH_STEP: begin
          q.push_back({bus.pc_in, bus.alu_in});
          if (q.size() > DEPTH) begin q.delete(0); ovf = 1; end
          exec_n++;
          if (exec_n == target) ph = PH_DONE;
          else if (ph == PH_STEP) ph = PH_PAUSE;
          else if (bus.halt_req) ph = PH_PAUSE;
        end
        PH_PAUSE:
          if (bus.start) ph = PH_RUN;
          else if (bus.single_step) ph = PH_STEP;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("cpu_reset", 64'(bus.cpu_reset), 64'(ph == PH_IDLE || ph == PH_HOLD));
      check("cpu_en", 64'(bus.cpu_en), 64'(ph == PH_RUN || ph == PH_STEP));
      check("busy", 64'(bus.busy),
            64'(ph == PH_HOLD || ph == PH_RUN || ph == PH_STEP || ph == PH_PAUSE));
      check("done", 64'(bus.done), 64'(ph == PH_DONE));
      check("cycles_run", 64'(bus.cycles_run), 64'(exec_n));
      check("trace_count", 64'(bus.trace_count), 64'(q.size()));
      check("trace_overflow", 64'(bus.trace_overflow), 64'(ovf));
      if (rd_ok) check("trace_rd_data", bus.trace_rd_data, rd_exp);
    end
  end

  // CPU stand-in: PC advances by 4 per executed cycle
  initial begin
    bus.pc_in = '0;
    bus.alu_in = 32'hA5A5_0000;
    forever begin
      @(posedge clk);
      #1;
      bus.pc_in  = 32'(exec_n * 4);
      bus.alu_in = 32'(exec_n * 4) ^ 32'hA5A5_0000;
    end
  end

  task automatic pulse_start(input int n);
    @(posedge clk); #1;
    bus.step_count = STEP_W'(n);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output int hold_n, output int en_n);
    bit seen;
    seen = 0; hold_n = 0; en_n = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
      else begin
        if (bus.busy && bus.cpu_reset) hold_n++;
        if (bus.cpu_en) en_n++;
      end
    end
    check("done_timeout", 64'(seen), 64'd1);
  endtask

  task automatic wait_run_at(input int n);
    bit seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.cpu_en && int'(bus.cycles_run) == n) seen = 1;
    end
    check("run_wait_timeout", 64'(seen), 64'd1);
  endtask

  task automatic read_trace(input int a, output logic [63:0] d);
    @(posedge clk); #1;
    bus.trace_rd_addr = AW'(a);
    @(posedge clk);
    @(negedge clk);
    d = bus.trace_rd_data;
  endtask

  task automatic do_step();
    @(posedge clk); #1;
    bus.single_step = 1'b1;
    @(posedge clk); #1;
    bus.single_step = 1'b0;
    @(negedge clk);
    check("step_en_hi", 64'(bus.cpu_en), 64'd1);
    @(negedge clk);
    check("step_en_lo", 64'(bus.cpu_en), 64'd0);
  endtask

  initial begin
    int hn, en;
    logic [63:0] d;
    bus.start = 0; bus.step_count = '0; bus.halt_req = 0;
    bus.single_step = 0; bus.trace_rd_addr = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_reset", 64'(bus.cpu_reset), 64'd1);
    check("rst_cpu_en", 64'(bus.cpu_en), 64'd0);
    check("rst_rd_data", bus.trace_rd_data, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Plain run of 12
    pulse_start(12);
    run_until_done(100, hn, en);
    check("t1_hold_cycles", 64'(hn), 64'd4);
    check("t1_en_cycles", 64'(en), 64'd12);
    check("t1_cycles_run", 64'(bus.cycles_run), 64'd12);

    // Trace readback
    check("t2_count", 64'(bus.trace_count), 64'd12);
    check("t2_ovf", 64'(bus.trace_overflow), 64'd0);
    read_trace(0, d);
    check("t2_rd0", d, {32'd0, 32'hA5A5_0000});
    read_trace(11, d);
    check("t2_rd11_pc", 64'(d[63:32]), 64'd44);

    // Overflow after 20 entries
    pulse_start(20);
    run_until_done(100, hn, en);
    check("t3_en_cycles", 64'(en), 64'd20);
    check("t3_count", 64'(bus.trace_count), 64'd16);
    check("t3_ovf", 64'(bus.trace_overflow), 64'd1);
    read_trace(0, d);
    check("t3_rd0_pc", 64'(d[63:32]), 64'd16);
    read_trace(15, d);
    check("t3_rd15_pc", 64'(d[63:32]), 64'd76);

    // Halt on 3rd cycle, two single steps, resume
    pulse_start(12);
    wait_run_at(2);
    bus.halt_req = 1'b1;
    @(posedge clk); #1;
    bus.halt_req = 1'b0;
    @(negedge clk);
    check("t4_paused_busy", 64'(bus.busy), 64'd1);
    check("t4_paused_en", 64'(bus.cpu_en), 64'd0);
    check("t4_paused_cycles", 64'(bus.cycles_run), 64'd3);
    do_step();
    do_step();
    check("t4_step_cycles", 64'(bus.cycles_run), 64'd5);
    pulse_start(1);
    run_until_done(100, hn, en);
    check("t4_resume_en", 64'(en), 64'd7);
    check("t4_final_cycles", 64'(bus.cycles_run), 64'd12);

    // Halt on the final cycle goes to DONE
    pulse_start(3);
    wait_run_at(2);
    bus.halt_req = 1'b1;
    @(posedge clk); #1;
    bus.halt_req = 1'b0;
    @(negedge clk);
    check("t5_halt_last_done", 64'(bus.done), 64'd1);
    check("t5_halt_last_busy", 64'(bus.busy), 64'd0);

    // step_count=0 in IDLE is ignored
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    pulse_start(0);
    repeat (3) @(negedge clk);
    check("t5_zero_busy", 64'(bus.busy), 64'd0);
    check("t5_zero_cpu_reset", 64'(bus.cpu_reset), 64'd1);

    // start during RUN has no effect
    pulse_start(8);
    wait_run_at(3);
    bus.step_count = 16'd2;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    run_until_done(100, hn, en);
    check("t5_run_start_cycles", 64'(bus.cycles_run), 64'd8);

    // Reset mid-run, then a clean run
    pulse_start(10);
    wait_run_at(6);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_cpu_reset", 64'(bus.cpu_reset), 64'd1);
    check("t6_cpu_en", 64'(bus.cpu_en), 64'd0);
    check("t6_cycles", 64'(bus.cycles_run), 64'd0);
    check("t6_count", 64'(bus.trace_count), 64'd0);
    pulse_start(5);
    run_until_done(100, hn, en);
    check("t6_rerun_cycles", 64'(bus.cycles_run), 64'd5);
    check("t6_rerun_count", 64'(bus.trace_count), 64'd5);
    read_trace(0, d);
    check("t6_rd0_pc", 64'(d[63:32]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
